// File: rtl/vdp_cpu_bridge.sv
`default_nettype none
// ============================================================================
// Module   : vdp_cpu_bridge
// Purpose  : Brings the asynchronous CPU read/write strobes into the pixel
//            clock domain through a synchroniser and a glitch filter, then
//            turns each filtered strobe assertion into exactly one
//            req/ack transaction to the VDP core.
// Options  : define CPU_BRIDGE_ACK_TIMEOUT_EN to abort requests that receive
//            no vdp_ack within ACK_TIMEOUT cycles (sets sticky timeout_err).
// Revision : 1.0 - initial release
// ============================================================================
module vdp_cpu_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       csr_n,
  input  logic       csw_n,
  input  logic [1:0] mode,
  input  logic [7:0] cdo,
  output logic [7:0] cdi,
  output logic       vdp_req,
  output logic       vdp_wrt,
  output logic [1:0] vdp_adr,
  output logic [7:0] vdp_dbo,
  input  logic       vdp_ack,
  input  logic [7:0] vdp_dbi,
  output logic       busy,
  output logic       timeout_err
);

  localparam int                FCNT_W    = 4;
  localparam logic [FCNT_W-1:0] FILT_LAST = FCNT_W'(FILTER_LEN);

  // Out-of-range parameters elaborate a module that does not exist, so a bad
  // configuration stops the build instead of silently misbehaving.
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    invalid_sync_stages_parameter u_bad ();
  end
  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_bad_filter_len
    invalid_filter_len_parameter u_bad ();
  end
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 65535) begin : g_bad_ack_timeout
    invalid_ack_timeout_parameter u_bad ();
  end

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Bit 0 carries csr_n, bit 1 carries csw_n throughout the strobe path.
  logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
  logic [1:0]                  samp;
  logic [1:0]                  filt_q, filt_d;
  logic [1:0][FCNT_W-1:0]      fcnt_q, fcnt_d;

  state_t     state_q, state_d;
  logic       req_q, req_d;
  logic       wrt_q, wrt_d;
  logic [1:0] adr_q, adr_d;
  logic [7:0] dbo_q, dbo_d;
  logic [7:0] cdi_q, cdi_d;
  logic       abort;

  // Shift both strobes one stage further down the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], csw_n, csr_n};
  end

  assign samp = sync_q[SYNC_STAGES-1];

  // Filter: count consecutive samples disagreeing with the current output;
  // once FILTER_LEN of them have been counted the output follows the sample.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (samp[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] == FILT_LAST) begin
        filt_d[i] = samp[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + 1'b1;
      end
    end
  end

  // Strobe path registers; reset presets strobes to the inactive level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      filt_q <= 2'b11;
      fcnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

`ifdef CPU_BRIDGE_ACK_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

  logic [15:0] tcnt_q, tcnt_d;
  logic        terr_q, terr_d;

  // Count cycles spent in ISSUE; an ack in the final cycle still wins.
  always_comb begin
    tcnt_d = (state_q == ST_ISSUE) ? tcnt_q + 16'd1 : 16'd0;
    abort  = (state_q == ST_ISSUE) && !vdp_ack && (tcnt_q == TO_LAST);
    terr_d = terr_q | abort;
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q <= '0;
      terr_q <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Transaction FSM: capture on a single low strobe, hold until ack (or
  // abort), then wait for both strobes to be released before re-arming.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wrt_d   = wrt_q;
    adr_d   = adr_q;
    dbo_d   = dbo_q;
    cdi_d   = cdi_q;
    case (state_q)
      ST_IDLE: begin
        // Both strobes low at once is an illegal CPU cycle and is ignored.
        if (filt_q[0] ^ filt_q[1]) begin
          adr_d   = mode;
          dbo_d   = cdo;
          wrt_d   = ~filt_q[1];
          req_d   = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (vdp_ack) begin
          req_d   = 1'b0;
          state_d = ST_RELEASE;
          if (!wrt_q) begin
            cdi_d = vdp_dbi;
          end
        end else if (abort) begin
          req_d   = 1'b0;
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (&filt_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state and request/response registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      wrt_q   <= 1'b0;
      adr_q   <= '0;
      dbo_q   <= '0;
      cdi_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wrt_q   <= wrt_d;
      adr_q   <= adr_d;
      dbo_q   <= dbo_d;
      cdi_q   <= cdi_d;
    end
  end

  assign vdp_req = req_q;
  assign vdp_wrt = wrt_q;
  assign vdp_adr = adr_q;
  assign vdp_dbo = dbo_q;
  assign cdi     = cdi_q;
  assign busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vdp_cpu_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdp_cpu_bridge
// Purpose  : Directed self-checking bench for vdp_cpu_bridge (default
//            SYNC_STAGES/FILTER_LEN, ACK_TIMEOUT=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vdp_cpu_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic       csr_n;
  logic       csw_n;
  logic [1:0] mode;
  logic [7:0] cdo;
  logic [7:0] cdi;
  logic       vdp_req;
  logic       vdp_wrt;
  logic [1:0] vdp_adr;
  logic [7:0] vdp_dbo;
  logic       vdp_ack;
  logic [7:0] vdp_dbi;
  logic       busy;
  logic       timeout_err;

  int checks   = 0;
  int failures = 0;
  int req_pulses = 0;
  logic req_prev = 1'b0;

  vdp_cpu_bridge #(
    .SYNC_STAGES(2),
    .FILTER_LEN (3),
    .ACK_TIMEOUT(10)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .csr_n      (csr_n),
    .csw_n      (csw_n),
    .mode       (mode),
    .cdo        (cdo),
    .cdi        (cdi),
    .vdp_req    (vdp_req),
    .vdp_wrt    (vdp_wrt),
    .vdp_adr    (vdp_adr),
    .vdp_dbo    (vdp_dbo),
    .vdp_ack    (vdp_ack),
    .vdp_dbi    (vdp_dbi),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Count rising edges of vdp_req to verify one request per strobe.
  always @(posedge clk) begin
    req_prev <= vdp_req;
    if (vdp_req && !req_prev) req_pulses <= req_pulses + 1;
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    csr_n   = 1'b1;
    csw_n   = 1'b1;
    mode    = 2'd0;
    cdo     = 8'h00;
    vdp_ack = 1'b0;
    vdp_dbi = 8'h00;
    tick(3);
    chk("rst_req",  {31'd0, vdp_req}, 32'd0);
    chk("rst_wrt",  {31'd0, vdp_wrt}, 32'd0);
    chk("rst_adr",  {30'd0, vdp_adr}, 32'd0);
    chk("rst_dbo",  {24'd0, vdp_dbo}, 32'd0);
    chk("rst_cdi",  {24'd0, cdi},     32'd0);
    chk("rst_busy", {31'd0, busy},    32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    reset = 1'b0;
    tick(2);

    // Write: strobe sampled at edge 0, request from edge 6, ack at edge 8.
    mode = 2'b01; cdo = 8'hA5; csw_n = 1'b0;
    tick(6);                                   // edges 0..5
    chk("wr_req_e5", {31'd0, vdp_req}, 32'd0);
    tick(1);                                   // edge 6
    chk("wr_req_e6", {31'd0, vdp_req}, 32'd1);
    chk("wr_wrt",    {31'd0, vdp_wrt}, 32'd1);
    chk("wr_adr",    {30'd0, vdp_adr}, 32'd1);
    chk("wr_dbo",    {24'd0, vdp_dbo}, 32'hA5);
    chk("wr_busy",   {31'd0, busy},    32'd1);
    mode = 2'b10; cdo = 8'h00;                 // captured values must hold
    tick(2);                                   // edges 7,8
    chk("wr_hold_req", {31'd0, vdp_req}, 32'd1);
    chk("wr_hold_adr", {30'd0, vdp_adr}, 32'd1);
    chk("wr_hold_dbo", {24'd0, vdp_dbo}, 32'hA5);
    vdp_ack = 1'b1; vdp_dbi = 8'hFF;
    tick(1);                                   // edge 9
    vdp_ack = 1'b0; vdp_dbi = 8'h00;
    chk("wr_req_e9", {31'd0, vdp_req}, 32'd0);
    chk("wr_cdi",    {24'd0, cdi},     32'd0);
    chk("wr_release_busy", {31'd0, busy}, 32'd1);
    csw_n = 1'b1;
    tick(8);
    chk("wr_idle",   {31'd0, busy}, 32'd0);
    chk("wr_pulses", req_pulses, 32'd1);

    // Read: ack with 3C, then a write must not disturb cdi.
    mode = 2'b10; csr_n = 1'b0;
    tick(7);
    chk("rd_req", {31'd0, vdp_req}, 32'd1);
    chk("rd_wrt", {31'd0, vdp_wrt}, 32'd0);
    chk("rd_adr", {30'd0, vdp_adr}, 32'd2);
    vdp_ack = 1'b1; vdp_dbi = 8'h3C;
    tick(1);
    vdp_ack = 1'b0; vdp_dbi = 8'h00;
    chk("rd_cdi", {24'd0, cdi},     32'h3C);
    chk("rd_req_drop", {31'd0, vdp_req}, 32'd0);
    csr_n = 1'b1;
    tick(8);
    mode = 2'b11; cdo = 8'h5A; csw_n = 1'b0;
    tick(7);
    chk("wr2_dbo", {24'd0, vdp_dbo}, 32'h5A);
    vdp_ack = 1'b1; vdp_dbi = 8'h77;
    tick(1);
    vdp_ack = 1'b0; vdp_dbi = 8'h00;
    chk("wr2_cdi_held", {24'd0, cdi}, 32'h3C);
    csw_n = 1'b1;
    tick(8);
    chk("wr2_pulses", req_pulses, 32'd3);

    // Stray ack in IDLE must be ignored.
    vdp_ack = 1'b1; vdp_dbi = 8'h99;
    tick(1);
    vdp_ack = 1'b0; vdp_dbi = 8'h00;
    chk("stray_ack_cdi",  {24'd0, cdi},  32'h3C);
    chk("stray_ack_busy", {31'd0, busy}, 32'd0);

    // Glitch: two-cycle low on csw_n is filtered out.
    csw_n = 1'b0;
    tick(2);
    csw_n = 1'b1;
    tick(10);
    chk("glitch_busy",   {31'd0, busy}, 32'd0);
    chk("glitch_pulses", req_pulses, 32'd3);

    // Both strobes low together: ignored.
    csr_n = 1'b0; csw_n = 1'b0;
    tick(12);
    chk("both_busy", {31'd0, busy},    32'd0);
    chk("both_req",  {31'd0, vdp_req}, 32'd0);
    csr_n = 1'b1; csw_n = 1'b1;
    tick(8);
    chk("both_pulses", req_pulses, 32'd3);

    // Early release: strobe returns high before ack; request persists.
    mode = 2'b00; csr_n = 1'b0;
    tick(7);
    chk("early_req", {31'd0, vdp_req}, 32'd1);
    csr_n = 1'b1;
    tick(8);
    chk("early_req_held", {31'd0, vdp_req}, 32'd1);
    chk("early_busy",     {31'd0, busy},    32'd1);
    vdp_ack = 1'b1; vdp_dbi = 8'hC3;
    tick(1);
    vdp_ack = 1'b0; vdp_dbi = 8'h00;
    chk("early_req_drop", {31'd0, vdp_req}, 32'd0);
    chk("early_cdi",      {24'd0, cdi},     32'hC3);
    chk("early_release",  {31'd0, busy},    32'd1);
    tick(1);
    chk("early_idle",     {31'd0, busy},    32'd0);
    chk("early_pulses",   req_pulses, 32'd4);

    // Reset during ISSUE, strobe held low across it.
    mode = 2'b01; cdo = 8'h11; csw_n = 1'b0;
    tick(7);
    chk("mid_req", {31'd0, vdp_req}, 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_rst_req",  {31'd0, vdp_req}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy},    32'd0);
    chk("mid_rst_cdi",  {24'd0, cdi},     32'd0);
    chk("mid_rst_dbo",  {24'd0, vdp_dbo}, 32'd0);
    chk("mid_rst_adr",  {30'd0, vdp_adr}, 32'd0);
    tick(6);                                   // edges 0..5 after reset
    chk("post_rst_req_e5", {31'd0, vdp_req}, 32'd0);
    tick(1);                                   // edge 6
    chk("post_rst_req_e6", {31'd0, vdp_req}, 32'd1);
    chk("post_rst_dbo",    {24'd0, vdp_dbo}, 32'h11);

`ifdef CPU_BRIDGE_ACK_TIMEOUT_EN
    // No ack: request is high for exactly 10 cycles then aborts.
    tick(9);                                   // edge 15
    chk("to_req_e15", {31'd0, vdp_req},     32'd1);
    chk("to_err_e15", {31'd0, timeout_err}, 32'd0);
    tick(1);                                   // edge 16
    chk("to_req_e16", {31'd0, vdp_req},     32'd0);
    chk("to_err_set", {31'd0, timeout_err}, 32'd1);
    chk("to_cdi",     {24'd0, cdi},         32'd0);
    csw_n = 1'b1;
    tick(8);
    chk("to_idle",    {31'd0, busy},        32'd0);
    chk("to_sticky",  {31'd0, timeout_err}, 32'd1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("to_err_clr", {31'd0, timeout_err}, 32'd0);
`else
    // No ack and no timeout: request waits indefinitely.
    tick(40);
    chk("wait_req",  {31'd0, vdp_req},     32'd1);
    chk("wait_terr", {31'd0, timeout_err}, 32'd0);
    vdp_ack = 1'b1;
    tick(1);
    vdp_ack = 1'b0;
    chk("wait_req_drop", {31'd0, vdp_req}, 32'd0);
    csw_n = 1'b1;
    tick(8);
    chk("wait_idle", {31'd0, busy}, 32'd0);
`endif
    chk("final_pulses", req_pulses, 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vdp_cpu_bridge.md
VDP_CPU_BRIDGE -- requirements
Module: vdp_cpu_bridge

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchroniser flops per CPU strobe (legal 2..4).
REQ-002 SHALL have parameter FILTER_LEN, default 3: consecutive identical synchronised samples required to change a filtered strobe (legal 1..15).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 255: cycles to wait for vdp_ack before abort (legal 1..65535).
REQ-004 SHALL have port clk, input, 1: single clock for all logic (pixel clock domain).
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port csr_n, input, 1: asynchronous CPU read strobe, active low.
REQ-007 SHALL have port csw_n, input, 1: asynchronous CPU write strobe, active low.
REQ-008 SHALL have port mode, input, 2: CPU port select (VDP register address bits).
REQ-009 SHALL have port cdo, input, 8: CPU write data.
REQ-010 SHALL have port cdi, output, 8: latched read data returned to the CPU.
REQ-011 SHALL have port vdp_req, output, 1: request to the VDP core.
REQ-012 SHALL have port vdp_wrt, output, 1: 1 = write, 0 = read, valid while vdp_req=1.
REQ-013 SHALL have port vdp_adr, output, 2: latched mode, valid while vdp_req=1.
REQ-014 SHALL have port vdp_dbo, output, 8: latched cdo, valid while vdp_req=1.
REQ-015 SHALL have port vdp_ack, input, 1: single-cycle completion from the VDP core.
REQ-016 SHALL have port vdp_dbi, input, 8: VDP read data, valid in the vdp_ack cycle.
REQ-017 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-018 SHALL have port timeout_err, output, 1: sticky flag, set on an aborted request.

Function
REQ-019 SHALL pass each strobe through SYNC_STAGES flops, then a filter that updates its output only after FILTER_LEN consecutive identical samples differing from the current output.
REQ-020 SHALL change the filtered strobe at the SYNC_STAGES+FILTER_LEN-th clock edge after the first edge sampling the new pin level (5 with defaults).
REQ-021 SHALL implement FSM states IDLE, ISSUE, RELEASE.
REQ-022 In IDLE, exactly one filtered strobe low SHALL capture mode into vdp_adr and cdo into vdp_dbo, set vdp_wrt = ~filtered csw_n, and enter ISSUE with vdp_req=1 on the next cycle.
REQ-023 In IDLE, both filtered strobes low SHALL be ignored: no request is issued and the FSM stays in IDLE.
REQ-024 In ISSUE, vdp_req, vdp_wrt, vdp_adr and vdp_dbo SHALL hold constant until vdp_ack=1; that cycle SHALL deassert vdp_req on the next edge and enter RELEASE.
REQ-025 On a read ack, SHALL register vdp_dbi into cdi; cdi SHALL hold until the next read ack; writes SHALL leave cdi unchanged.
REQ-026 A strobe released during ISSUE SHALL NOT cancel the request; the request completes normally.
REQ-027 In RELEASE, SHALL return to IDLE on the first cycle both filtered strobes are high; exactly one request SHALL be issued per strobe assertion.
REQ-028 vdp_ack received outside ISSUE SHALL be ignored.

Reset
REQ-029 reset=1 at a clock edge SHALL force IDLE and set vdp_req=0, vdp_wrt=0, vdp_adr=0, vdp_dbo=0, cdi=0, busy=0, timeout_err=0.
REQ-030 Reset SHALL preset synchroniser and filter outputs to 1 (inactive) and clear the filter counters.
REQ-031 reset asserted mid-ISSUE SHALL drop vdp_req on that edge; a strobe still held low after reset SHALL issue a fresh request after the REQ-020 latency.

Configuration
REQ-032 With macro CPU_BRIDGE_ACK_TIMEOUT_EN defined: in ISSUE, a counter SHALL abort after ACK_TIMEOUT cycles without vdp_ack, deassert vdp_req, set timeout_err, leave cdi unchanged, and enter RELEASE.
REQ-033 Without CPU_BRIDGE_ACK_TIMEOUT_EN: ISSUE SHALL wait indefinitely, no counter SHALL be synthesised, and timeout_err SHALL be tied to 0.

Verification
REQ-034 Write: defaults, mode=2'b01, cdo=8'hA5, csw_n low at edge 0 -> vdp_req=1 from edge 6 with vdp_wrt=1, vdp_adr=1, vdp_dbo=8'hA5; ack at edge 8 -> vdp_req=0 at edge 9; exactly one request.
REQ-035 Read: csr_n low; ack with vdp_dbi=8'h3C -> cdi=8'h3C the cycle after ack and held through a following write.
REQ-036 Glitch: csw_n low for 2 cycles only (FILTER_LEN=3) -> no vdp_req; both strobes low together -> no vdp_req.
REQ-037 Early release: csr_n high before ack -> request held until ack, then IDLE once both strobes are filtered high.
REQ-038 Reset during ISSUE -> all outputs 0 the next cycle; strobe still low -> new request 6 cycles after reset deasserts.
REQ-039 With CPU_BRIDGE_ACK_TIMEOUT_EN, ACK_TIMEOUT=10, no ack -> vdp_req drops after 10 cycles and timeout_err=1 until reset.
